keyed_lock_wrapper: RTL and testbench



---
 rtl/lock_pkg.sv | 23 ++
 rtl/keyed_lock_wrapper_key_lut2.sv | 15 +
 rtl/keyed_lock_wrapper.sv | 157 +++++++++++++++
 tb/tb_keyed_lock_wrapper.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared state encoding and key-layout helpers for the keyed lock wrapper.
// The CHECK and ERROR states are only reachable when KEY_PARITY_EN is defined.
package lock_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ACTIVE = 2'd1,
        CHECK  = 2'd2,
        ERROR  = 2'd3
    } lock_state_e;

    localparam int LUT_KEY_W = 4;

    // Key fields sit LSB first: input XOR key, output XOR key, then one nibble per LUT.
    function automatic int oxor_offset(input int xin_w);
        return xin_w;
    endfunction

    function automatic int lut_offset(input int xin_w, input int xout_w);
        return xin_w + xout_w;
    endfunction

endpackage

// File: rtl/keyed_lock_wrapper_key_lut2.sv
// Single key-programmed 2-input LUT. The key nibble is {p4,p3,p2,p1}.
// The output is forced low while the enable is deasserted.
module key_lut2
    import lock_pkg::*;
(
    input  logic [LUT_KEY_W-1:0] lut_key_i,
    input  logic                 a_i,
    input  logic                 b_i,
    input  logic                 en_i,
    output logic                 y_o
);

    assign y_o = en_i & lut_key_i[{a_i, b_i}];

endmodule

// File: rtl/keyed_lock_wrapper.sv
// Key-controlled locking wrapper around a combinational core: serial key load,
// XOR-keyed I/O and key-programmed LUTs. Optional macro KEY_PARITY_EN adds a parity check.
module keyed_lock_wrapper
    import lock_pkg::*;
#(
    parameter int IN_W   = 36,
    parameter int OUT_W  = 7,
    parameter int XIN_W  = 10,
    parameter int XOUT_W = 2,
    parameter int N_LUT  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_bit,
    input  logic             key_valid,
    input  logic             key_clear,
    output logic             key_ready,
`ifdef KEY_PARITY_EN
    output logic             key_err,
`endif
    input  logic [IN_W-1:0]  data_in,
    input  logic             in_valid,
    output logic [IN_W-1:0]  core_in,
    input  logic [OUT_W-1:0] core_out,
    output logic [OUT_W-1:0] data_out,
    output logic             out_valid,
    input  logic [N_LUT-1:0] lut_a,
    input  logic [N_LUT-1:0] lut_b,
    output logic [N_LUT-1:0] lut_y
);

    localparam int KEY_W    = XIN_W + XOUT_W + LUT_KEY_W * N_LUT;
    localparam int CNT_W    = $clog2(KEY_W + 1);
    localparam int OXOR_OFF = oxor_offset(XIN_W);
    localparam int LUT_OFF  = lut_offset(XIN_W, XOUT_W);

    lock_state_e      state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic             active;

    assign active = (state_q == ACTIVE);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD: begin
                if (key_clear) begin
                    key_d = '0;
                    cnt_d = '0;
                end else if (key_valid) begin
                    key_d = {key_bit, key_q[KEY_W-1:1]};
                    if (cnt_q != CNT_W'(KEY_W)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == CNT_W'(KEY_W - 1)) begin
`ifdef KEY_PARITY_EN
                        state_d = CHECK;
`else
                        state_d = ACTIVE;
`endif
                    end
                end
            end
`ifdef KEY_PARITY_EN
            // The trailing bit makes the key plus parity bit even.
            CHECK: begin
                if (key_clear) begin
                    state_d = LOAD;
                    key_d   = '0;
                    cnt_d   = '0;
                end else if (key_valid) begin
                    state_d = (key_bit == ^key_q) ? ACTIVE : ERROR;
                end
            end
            ERROR: begin
                if (key_clear) begin
                    state_d = LOAD;
                    key_d   = '0;
                    cnt_d   = '0;
                end
            end
`endif
            ACTIVE: begin
                if (key_clear) begin
                    state_d = LOAD;
                    key_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = LOAD;
                key_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    // A clear in ACTIVE wins over a same-cycle capture; outside ACTIVE the output is held at zero.
    always_comb begin
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        if (active) begin
            if (!key_clear && in_valid) begin
                data_out_d  = core_out ^ OUT_W'(key_q[OXOR_OFF +: XOUT_W]);
                out_valid_d = 1'b1;
            end
        end else begin
            data_out_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign core_in   = data_in ^ IN_W'(key_q[XIN_W-1:0]);
    assign key_ready = active;
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
`ifdef KEY_PARITY_EN
    assign key_err   = (state_q == ERROR);
`endif

    for (genvar i = 0; i < N_LUT; i++) begin : g_lut
        key_lut2 u_lut (
            .lut_key_i (key_q[LUT_OFF + LUT_KEY_W * i +: LUT_KEY_W]),
            .a_i       (lut_a[i]),
            .b_i       (lut_b[i]),
            .en_i      (active),
            .y_o       (lut_y[i])
        );
    end

endmodule

// File: tb/tb_keyed_lock_wrapper.sv
// Self-checking bench for keyed_lock_wrapper: directed key loads plus randomized
// traffic compared against a key-level behavioural model (KEY_PARITY_EN aware).
module tb_keyed_lock_wrapper;

    localparam int IN_W   = 36;
    localparam int OUT_W  = 7;
    localparam int XIN_W  = 10;
    localparam int XOUT_W = 2;
    localparam int N_LUT  = 1;
    localparam int KEY_W  = XIN_W + XOUT_W + 4 * N_LUT;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_bit, key_valid, key_clear, key_ready;
    logic [IN_W-1:0]  data_in, core_in;
    logic             in_valid;
    logic [OUT_W-1:0] core_out, data_out;
    logic             out_valid;
    logic [N_LUT-1:0] lut_a, lut_b, lut_y;
`ifdef KEY_PARITY_EN
    logic             key_err;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Model state: the loaded key as a number, whether the lock is open, and the expected output register.
    logic [KEY_W-1:0] mKey      = '0;
    bit               mActive   = 1'b0;
    logic [OUT_W-1:0] mDataOut  = '0;
    logic             mOutValid = 1'b0;

    always #5 clk = ~clk;

    keyed_lock_wrapper #(
        .IN_W(IN_W), .OUT_W(OUT_W), .XIN_W(XIN_W), .XOUT_W(XOUT_W), .N_LUT(N_LUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_bit   (key_bit),
        .key_valid (key_valid),
        .key_clear (key_clear),
        .key_ready (key_ready),
`ifdef KEY_PARITY_EN
        .key_err   (key_err),
`endif
        .data_in   (data_in),
        .in_valid  (in_valid),
        .core_in   (core_in),
        .core_out  (core_out),
        .data_out  (data_out),
        .out_valid (out_valid),
        .lut_a     (lut_a),
        .lut_b     (lut_b),
        .lut_y     (lut_y)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] expCoreIn(input logic [IN_W-1:0] d);
        logic [63:0] mask;
        mask = (64'd1 << XIN_W) - 64'd1;
        return IN_W'(64'(d) ^ (64'(mKey) & mask));
    endfunction

    function automatic logic [OUT_W-1:0] expOutKey();
        logic [63:0] mask;
        mask = (64'd1 << XOUT_W) - 64'd1;
        return OUT_W'((64'(mKey) >> XIN_W) & mask);
    endfunction

    function automatic logic [N_LUT-1:0] expLut(input logic [N_LUT-1:0] a, input logic [N_LUT-1:0] b);
        logic [N_LUT-1:0] y;
        logic [63:0]      nib;
        y = '0;
        for (int i = 0; i < N_LUT; i++) begin
            nib  = (64'(mKey) >> (XIN_W + XOUT_W + 4 * i)) & 64'hF;
            y[i] = mActive ? nib[2 * a[i] + b[i]] : 1'b0;
        end
        return y;
    endfunction

    // Advance one clock, predicting the output register from the inputs seen at the edge.
    task automatic applyStimulus();
        if (mActive && !key_clear) begin
            if (in_valid) begin
                mDataOut  = core_out ^ expOutKey();
                mOutValid = 1'b1;
            end else begin
                mOutValid = 1'b0;
            end
        end else begin
            mOutValid = 1'b0;
            if (!mActive) mDataOut = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic loadKey(input logic [KEY_W-1:0] k, input bit goodParity);
        for (int i = 0; i < KEY_W; i++) begin
            key_bit   = k[i];
            key_valid = 1'b1;
            if (i == KEY_W - 1) checkOutput("ready_before_last_bit", 64'(key_ready), 64'd0);
            applyStimulus();
        end
`ifdef KEY_PARITY_EN
        key_bit = (^k) ^ ~goodParity;
        checkOutput("ready_before_parity", 64'(key_ready), 64'd0);
        applyStimulus();
        mActive = goodParity;
        checkOutput("key_err_after_load", 64'(key_err), 64'(!goodParity));
`else
        mActive = 1'b1;
`endif
        key_valid = 1'b0;
        mKey      = k;
        checkOutput("ready_after_load", 64'(key_ready), 64'(mActive));
    endtask

    task automatic randomTraffic(input int n);
        for (int i = 0; i < n; i++) begin
            data_in  = IN_W'({$urandom, $urandom});
            core_out = OUT_W'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            lut_a    = N_LUT'($urandom);
            lut_b    = N_LUT'($urandom);
            #1;
            checkOutput("rand_core_in", 64'(core_in), 64'(expCoreIn(data_in)));
            checkOutput("rand_lut_y", 64'(lut_y), 64'(expLut(lut_a, lut_b)));
            applyStimulus();
            checkOutput("rand_data_out", 64'(data_out), 64'(mDataOut));
            checkOutput("rand_out_valid", 64'(out_valid), 64'(mOutValid));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0]       xorTab;
        logic [KEY_W-1:0] randKey;
        xorTab    = 4'b0110;
        rst_n     = 1'b0;
        key_bit   = 1'b0;
        key_valid = 1'b0;
        key_clear = 1'b0;
        data_in   = '0;
        in_valid  = 1'b0;
        core_out  = '0;
        lut_a     = '0;
        lut_b     = '0;

        #12;
        checkOutput("rst_key_ready", 64'(key_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_data_out", 64'(data_out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        loadKey(16'h6FFF, 1'b1);

        data_in  = '0;
        core_out = 7'h00;
        in_valid = 1'b1;
        #1;
        checkOutput("default_core_in", 64'(core_in), 64'h3FF);
        applyStimulus();
        in_valid = 1'b0;
        checkOutput("default_data_out", 64'(data_out), 64'h03);
        checkOutput("default_out_valid", 64'(out_valid), 64'd1);
        applyStimulus();
        checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
        checkOutput("idle_data_hold", 64'(data_out), 64'h03);

        for (int ab = 0; ab < 4; ab++) begin
            lut_a = N_LUT'(ab >> 1);
            lut_b = N_LUT'(ab & 1);
            #1;
            checkOutput("lut_xor_active", 64'(lut_y), 64'(xorTab[ab]));
        end

        randomTraffic(20);

        key_clear = 1'b1;
        applyStimulus();
        key_clear = 1'b0;
        mActive   = 1'b0;
        mKey      = '0;
        checkOutput("clear_key_ready", 64'(key_ready), 64'd0);
        checkOutput("clear_out_valid", 64'(out_valid), 64'd0);
        for (int ab = 0; ab < 4; ab++) begin
            lut_a = N_LUT'(ab >> 1);
            lut_b = N_LUT'(ab & 1);
            #1;
            checkOutput("lut_load_zero", 64'(lut_y), 64'd0);
        end
        randomTraffic(4);

        // Partial key, then a clear that collides with key_valid; only the later full key must count.
        for (int i = 0; i < 8; i++) begin
            key_bit   = 1'($urandom);
            key_valid = 1'b1;
            applyStimulus();
        end
        key_clear = 1'b1;
        key_bit   = 1'b1;
        applyStimulus();
        key_clear = 1'b0;
        key_valid = 1'b0;
        data_in   = IN_W'(36'h0_0000_03FF);
        #1;
        checkOutput("clear_discards_bits", 64'(core_in), 64'h3FF);
        checkOutput("clear_not_ready", 64'(key_ready), 64'd0);
        randKey = KEY_W'($urandom);
        loadKey(randKey, 1'b1);
        randomTraffic(20);

        data_in  = IN_W'({$urandom, $urandom});
        core_out = 7'h7C;
        in_valid = 1'b1;
        applyStimulus();
        checkOutput("pre_reset_data_out", 64'(data_out), 64'(mDataOut));
        #2;
        rst_n = 1'b0;
        #1;
        mActive   = 1'b0;
        mKey      = '0;
        mDataOut  = '0;
        mOutValid = 1'b0;
        checkOutput("async_rst_data_out", 64'(data_out), 64'd0);
        checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_key_ready", 64'(key_ready), 64'd0);
        checkOutput("async_rst_core_in", 64'(core_in), 64'(data_in));
        #2;
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("load_data_out_zero", 64'(data_out), 64'd0);
        checkOutput("load_out_valid_zero", 64'(out_valid), 64'd0);
        in_valid = 1'b0;

`ifdef KEY_PARITY_EN
        randKey = KEY_W'($urandom);
        loadKey(randKey, 1'b0);
        in_valid = 1'b1;
        core_out = 7'h7F;
        lut_a    = '1;
        lut_b    = '0;
        #1;
        checkOutput("err_lut_y", 64'(lut_y), 64'd0);
        applyStimulus();
        checkOutput("err_data_out", 64'(data_out), 64'd0);
        checkOutput("err_out_valid", 64'(out_valid), 64'd0);
        in_valid  = 1'b0;
        key_clear = 1'b1;
        applyStimulus();
        key_clear = 1'b0;
        mKey      = '0;
        checkOutput("err_cleared", 64'(key_err), 64'd0);
        loadKey(randKey, 1'b1);
        randomTraffic(6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
